spi_slave_control: RTL and testbench

Responder end of the team's SPI link. Sits on the peripheral side of the serial bus driven by the SPI master controller and oversamples SCLK, CS_n and MOSI in the system clock domain. It captures received bytes LSB-first into a 32-bit word with a byte fill level. It also returns a preloaded 32-bit word on MISO, with byte-valid padding, matching the master's framing.

---
 rtl/spi_slave_control.sv | 153 +++++++++++++++
 tb/tb_spi_slave_control.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_control.sv
// SPI responder (CPOL=1): oversampled pins, LSB-first rx word assembly, padded tx return.
// Pin edge to internal action is SYNC_STAGES+1 clk_i cycles. There is no backpressure; tx_load_i is accepted only while idle.
module spi_slave_control #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        spi_clk_i,
    input  logic        spi_cs_n_i,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o,
    input  logic [31:0] tx_data_i,
    input  logic [2:0]  tx_bytes_valid_i,
    input  logic        tx_load_i,
    output logic        tx_ready_o,
    output logic [31:0] rx_data_o,
    output logic [2:0]  rx_bytes_valid_o,
    output logic        rx_word_valid_o,
    output logic        busy_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t state_q;
    state_t state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;

    logic sclk_s;
    logic cs_low;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;

    logic [31:0] tx_buf;
    logic [2:0]  tx_cnt;
    logic [2:0]  bit_cnt;
    logic [2:0]  byte_cnt;
    logic [2:0]  rx_fill;
    logic [6:0]  rx_shift;
    logic [7:0]  rx_byte;

    // Synchronisers flush to the bus idle levels so reset never fakes an edge.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sclk_sync <= '1;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            sclk_prev <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_low    = ~cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign rx_byte   = {mosi_s, rx_shift};

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:   if (cs_low)  state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (!cs_low) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_ready_o = (state_q == ST_IDLE);
        busy_o     = (state_q == ST_ACTIVE);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            tx_buf           <= '0;
            tx_cnt           <= '0;
            bit_cnt          <= '0;
            byte_cnt         <= '0;
            rx_fill          <= '0;
            rx_shift         <= '0;
            rx_data_o        <= '0;
            rx_bytes_valid_o <= '0;
            rx_word_valid_o  <= 1'b0;
            spi_miso_o       <= 1'b1;
        end else begin
            rx_word_valid_o <= 1'b0;
            if (state_q == ST_IDLE) begin
                spi_miso_o <= 1'b1;
                if (tx_load_i) begin
                    tx_buf <= tx_data_i;
                    tx_cnt <= (tx_bytes_valid_i > 3'd4) ? 3'd4 : tx_bytes_valid_i;
                end
                if (cs_low) begin
                    bit_cnt          <= '0;
                    byte_cnt         <= '0;
                    rx_fill          <= '0;
                    rx_data_o        <= '0;
                    rx_bytes_valid_o <= '0;
                end
            end else if (!cs_low) begin
                // Deselect overrides any coincident SCLK edge; the partial byte is dropped.
                spi_miso_o <= 1'b1;
                bit_cnt    <= '0;
            end else begin
                if (sclk_fall) begin
                    spi_miso_o <= (byte_cnt < tx_cnt) ? tx_buf[{byte_cnt[1:0], bit_cnt}] : 1'b1;
                end
                if (sclk_rise) begin
                    if (bit_cnt == 3'd7) begin
                        bit_cnt <= '0;
                        if (byte_cnt != 3'd4) begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                        if (rx_fill < 3'd4) begin
                            rx_data_o[{rx_fill[1:0], 3'b000} +: 8] <= rx_byte;
                            rx_fill          <= rx_fill + 3'd1;
                            rx_bytes_valid_o <= rx_fill + 3'd1;
                            rx_word_valid_o  <= (rx_fill == 3'd3);
                        end else begin
                            rx_data_o        <= {24'b0, rx_byte};
                            rx_fill          <= 3'd1;
                            rx_bytes_valid_o <= 3'd1;
                        end
                    end else begin
                        rx_shift[bit_cnt] <= mosi_s;
                        bit_cnt           <= bit_cnt + 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_control.sv
// Directed bench for spi_slave_control: a bit-banged SPI master with hand-computed expectations.
module tb_spi_slave_control;

    localparam int SS = 2;
    localparam int HP = 5;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        spi_clk_i;
    logic        spi_cs_n_i;
    logic        spi_mosi_i;
    logic        spi_miso_o;
    logic [31:0] tx_data_i;
    logic [2:0]  tx_bytes_valid_i;
    logic        tx_load_i;
    logic        tx_ready_o;
    logic [31:0] rx_data_o;
    logic [2:0]  rx_bytes_valid_o;
    logic        rx_word_valid_o;
    logic        busy_o;

    always #5 clk_i = ~clk_i;

    spi_slave_control #(.SYNC_STAGES(SS)) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .spi_clk_i        (spi_clk_i),
        .spi_cs_n_i       (spi_cs_n_i),
        .spi_mosi_i       (spi_mosi_i),
        .spi_miso_o       (spi_miso_o),
        .tx_data_i        (tx_data_i),
        .tx_bytes_valid_i (tx_bytes_valid_i),
        .tx_load_i        (tx_load_i),
        .tx_ready_o       (tx_ready_o),
        .rx_data_o        (rx_data_o),
        .rx_bytes_valid_o (rx_bytes_valid_o),
        .rx_word_valid_o  (rx_word_valid_o),
        .busy_o           (busy_o)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Word-valid pulses counted from the opposite clock edge.
    int          wv_total = 0;
    logic [31:0] wv_data  = '0;
    always @(negedge clk_i) begin
        if (rx_word_valid_o) begin
            wv_total++;
            wv_data = rx_data_o;
        end
    end

    logic [7:0]  fb [8];
    logic [7:0]  mb [8];
    logic [2:0]  bvs [8];
    logic [31:0] ds [8];
    logic        busy_mid, rdy_mid, rdy_load;
    logic [2:0]  bv_start;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic set_fb(input logic [63:0] v);
        for (int k = 0; k < 8; k++) fb[k] = v[8*k +: 8];
    endtask

    task automatic load_tx(input logic [31:0] d, input logic [2:0] n);
        tx_data_i        = d;
        tx_bytes_valid_i = n;
        tx_load_i        = 1'b1;
        cyc(1);
        tx_load_i        = 1'b0;
    endtask

    // Master drives MOSI on SCLK fall, slave samples on rise; MISO is read just before each rise.
    task automatic spi_frame(input int nbits, input int load_bit);
        spi_cs_n_i = 1'b0;
        cyc(HP);
        busy_mid = busy_o;
        rdy_mid  = tx_ready_o;
        bv_start = rx_bytes_valid_o;
        for (int i = 0; i < nbits; i++) begin
            spi_clk_i  = 1'b0;
            spi_mosi_i = fb[i/8][i%8];
            cyc(HP);
            mb[i/8][i%8] = spi_miso_o;
            if (i == load_bit) begin
                tx_data_i        = 32'hFFFF_FFFF;
                tx_bytes_valid_i = 3'd4;
                tx_load_i        = 1'b1;
                rdy_load         = tx_ready_o;
                cyc(1);
                tx_load_i        = 1'b0;
            end
            spi_clk_i = 1'b1;
            cyc(HP);
            if (i % 8 == 7) begin
                bvs[i/8] = rx_bytes_valid_o;
                ds[i/8]  = rx_data_o;
            end
        end
    endtask

    task automatic end_frame;
        spi_cs_n_i = 1'b1;
        cyc(SS + 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          wv0;
        logic [63:0] e;

        rstn_i = 1'b0; spi_clk_i = 1'b1; spi_cs_n_i = 1'b1; spi_mosi_i = 1'b0;
        tx_data_i = '0; tx_bytes_valid_i = '0; tx_load_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            fb[k] = '0; mb[k] = '0; bvs[k] = '0; ds[k] = '0;
        end
        busy_mid = 1'b0; rdy_mid = 1'b0; rdy_load = 1'b1; bv_start = '0;

        // Reset with SCLK toggling
        for (int k = 0; k < 3; k++) begin
            spi_clk_i = ~spi_clk_i;
            cyc(1);
        end
        check_val("rst_miso",   32'(spi_miso_o),       32'd1);
        check_val("rst_ready",  32'(tx_ready_o),       32'd1);
        check_val("rst_bv",     32'(rx_bytes_valid_o), 32'd0);
        check_val("rst_busy",   32'(busy_o),           32'd0);
        check_val("rst_data",   rx_data_o,             32'd0);
        check_val("rst_wv",     32'(rx_word_valid_o),  32'd0);
        spi_clk_i = 1'b1;
        cyc(2);
        rstn_i = 1'b1;
        cyc(4);

        // Full 4-byte word
        load_tx(32'hA5C3_0F81, 3'd4);
        set_fb(64'h0000_0000_1234_5678);
        wv0 = wv_total;
        spi_frame(32, -1);
        check_val("full_busy",  32'(busy_mid), 32'd1);
        check_val("full_rdy",   32'(rdy_mid),  32'd0);
        check_val("full_bv0",   32'(bv_start), 32'd0);
        e = 64'h0000_0000_A5C3_0F81;
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("full_miso%0d", k), 32'(mb[k]), 32'(e[8*k +: 8]));
            check_val($sformatf("full_bv%0d", k + 1), 32'(bvs[k]), k + 1);
        end
        check_val("full_data",  ds[3],             32'h1234_5678);
        check_val("full_wvcnt", wv_total - wv0,    32'd1);
        check_val("full_wvdat", wv_data,           32'h1234_5678);
        end_frame();
        check_val("full_idle",  32'(busy_o),       32'd0);
        check_val("full_ready", 32'(tx_ready_o),   32'd1);
        check_val("full_mosi1", 32'(spi_miso_o),   32'd1);
        check_val("full_hold",  rx_data_o,         32'h1234_5678);
        cyc(3);

        // Padding: only two valid tx bytes
        load_tx(32'hDEAD_BEEF, 3'd2);
        set_fb(64'h0000_0000_4433_2211);
        spi_frame(32, -1);
        e = 64'h0000_0000_FFFF_BEEF;
        for (int k = 0; k < 4; k++)
            check_val($sformatf("pad_miso%0d", k), 32'(mb[k]), 32'(e[8*k +: 8]));
        check_val("pad_data", ds[3], 32'h4433_2211);
        end_frame();
        cyc(3);

        // Wrap: 6-byte frame, tx count 7 clamps to 4
        load_tx(32'h1357_9BDF, 3'd7);
        set_fb(64'h0000_0605_0403_0201);
        wv0 = wv_total;
        spi_frame(48, -1);
        e = 64'h0000_FFFF_1357_9BDF;
        for (int k = 0; k < 6; k++)
            check_val($sformatf("wrap_miso%0d", k), 32'(mb[k]), 32'(e[8*k +: 8]));
        check_val("wrap_wvcnt", wv_total - wv0,         32'd1);
        check_val("wrap_wvdat", wv_data,                32'h0403_0201);
        check_val("wrap_bv5",   32'(bvs[4]),            32'd1);
        check_val("wrap_d5",    ds[4],                  32'h0000_0005);
        check_val("wrap_data",  rx_data_o,              32'h0000_0605);
        check_val("wrap_bv",    32'(rx_bytes_valid_o),  32'd2);
        end_frame();
        cyc(3);

        // Abort after 13 bits of AA,55
        set_fb(64'h0000_0000_0000_55AA);
        spi_frame(13, -1);
        spi_cs_n_i = 1'b1;
        cyc(SS + 1);
        check_val("abort_busy", 32'(busy_o),           32'd0);
        check_val("abort_bv",   32'(rx_bytes_valid_o), 32'd1);
        check_val("abort_data", rx_data_o,             32'h0000_00AA);
        check_val("abort_miso", 32'(spi_miso_o),       32'd1);
        cyc(3);
        set_fb(64'h0000_0000_0000_003C);
        spi_frame(8, -1);
        check_val("next_bv0",  32'(bv_start), 32'd0);
        check_val("next_bv",   32'(bvs[0]),   32'd1);
        check_val("next_data", ds[0],         32'h0000_003C);
        end_frame();
        cyc(3);

        // Load gating during an active frame
        load_tx(32'h6C3A_9E12, 3'd4);
        set_fb(64'h0000_0000_0000_0000);
        spi_frame(32, 3);
        check_val("gate_rdy", 32'(rdy_load), 32'd0);
        e = 64'h0000_0000_6C3A_9E12;
        for (int k = 0; k < 4; k++)
            check_val($sformatf("gate_miso%0d", k), 32'(mb[k]), 32'(e[8*k +: 8]));
        end_frame();
        cyc(3);
        spi_frame(8, -1);
        check_val("gate_keep", 32'(mb[0]), 32'h12);
        end_frame();
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
